// File: rtl/alu_multicycle.sv
// alu_multicycle: handshake-driven ALU. Simple ops complete in one cycle;
// MUL/MULHU use an iterative shift-add multiplier (WIDTH cycles).
// Optional divider (DIVU/REMU, restoring, WIDTH cycles) is built only when
// the macro ALU_MULTICYCLE_DIV_EN is defined; otherwise 1100/1101 act as
// reserved opcodes.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_MULTICYCLE_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_a;      // multiplicand, or divisor
  logic [2*WIDTH-1:0]     r_acc;    // {hi, lo} iteration accumulator
  logic [SHW-1:0]         r_cnt;
  logic                   r_hi;     // ALUControl[0]: MULHU / REMU pick the upper half
  logic [WIDTH-1:0]       r_res;
  logic                   r_zero;

  logic [SHW-1:0]         w_shamt;
  logic                   w_is_mul;
  logic                   w_last;
  logic [WIDTH-1:0]       w_alu_res;
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH-1:0]       w_mul_res;

  assign w_shamt  = SrcB[SHW-1:0];
  assign w_is_mul = (ALUControl == OP_MUL) || (ALUControl == OP_MULHU);
  assign w_last   = (r_cnt == SHW'(WIDTH-1));

  // Shift-add step: multiplier sits in the low half and shifts out LSB-first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_mul_res  = r_hi ? w_mul_next[2*WIDTH-1:WIDTH] : w_mul_next[WIDTH-1:0];

`ifdef ALU_MULTICYCLE_DIV_EN
  logic                   w_is_div;
  logic [2*WIDTH:0]       w_div_shift;
  logic [WIDTH:0]         w_div_trial;
  logic [2*WIDTH-1:0]     w_div_next;
  logic [WIDTH-1:0]       w_div_res;

  // A zero divisor never enters the iterative path; it is resolved in one cycle.
  assign w_is_div    = ((ALUControl == OP_DIVU) || (ALUControl == OP_REMU)) && (SrcB != '0);
  // Restoring step: {remainder, quotient} shifts left, quotient bit enters at LSB.
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_a};
  assign w_div_next  = w_div_trial[WIDTH]
                     ? {w_div_shift[2*WIDTH-1:WIDTH], w_div_shift[WIDTH-1:1], 1'b0}
                     : {w_div_trial[WIDTH-1:0],       w_div_shift[WIDTH-1:1], 1'b1};
  assign w_div_res   = r_hi ? w_div_next[2*WIDTH-1:WIDTH] : w_div_next[WIDTH-1:0];
`endif

  // Single-cycle result straight from the request operands.
  always_comb begin
    w_alu_res = '0;
    case (ALUControl)
      OP_ADD:  w_alu_res = SrcA + SrcB;
      OP_SUB:  w_alu_res = SrcA - SrcB;
      OP_AND:  w_alu_res = SrcA & SrcB;
      OP_OR:   w_alu_res = SrcA | SrcB;
      OP_XOR:  w_alu_res = SrcA ^ SrcB;
      OP_SLL:  w_alu_res = SrcA << w_shamt;
      OP_SRL:  w_alu_res = SrcA >> w_shamt;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SRA:  w_alu_res = WIDTH'($signed(SrcA) >>> w_shamt);
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
`ifdef ALU_MULTICYCLE_DIV_EN
      OP_DIVU: w_alu_res = (SrcB == '0) ? '1 : '0;
      OP_REMU: w_alu_res = (SrcB == '0) ? SrcA : '0;
`endif
      default: w_alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_is_mul)      w_next = S_MUL;
`ifdef ALU_MULTICYCLE_DIV_EN
          else if (w_is_div) w_next = S_DIV;
`endif
          else               w_next = S_DONE;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result register; result only changes on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_hi   <= 1'b0;
      r_res  <= '0;
      r_zero <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt <= '0;
            r_hi  <= ALUControl[0];
            if (w_is_mul) begin
              r_a   <= SrcA;
              r_acc <= {{WIDTH{1'b0}}, SrcB};
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            else if (w_is_div) begin
              r_a   <= SrcB;
              r_acc <= {{WIDTH{1'b0}}, SrcA};
            end
`endif
            else begin
              r_res  <= w_alu_res;
              r_zero <= (w_alu_res == '0);
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_res  <= w_mul_res;
            r_zero <= (w_mul_res == '0);
          end
        end
`ifdef ALU_MULTICYCLE_DIV_EN
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_res  <= w_div_res;
            r_zero <= (w_div_res == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ALUResult = r_res;
  assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): vector table plus
// backpressure and mid-multiply reset sequences.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input int lat, input int bsy);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.res = res; v.z = z; v.lat = lat; v.bsy = bsy;
    vq.push_back(v);
  endtask

  // Issue one request, wait (bounded) for the result, then complete the handshake.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat, output int bcnt);
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; ALUControl = 4'b0001;
    lat = 0; bcnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid) break;
    end
    res = ALUResult; z = Zero;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bcnt;
    int          seen;

    add_vec("ADD",      4'b0000, 32'd10,        32'd5,         32'd15,        1'b0, 1, 0);
    add_vec("SUB",      4'b0001, 32'd10,        32'd10,        32'd0,         1'b1, 1, 0);
    add_vec("AND",      4'b0010, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1'b0, 1, 0);
    add_vec("OR",       4'b0011, 32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 1'b0, 1, 0);
    add_vec("XOR",      4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1, 0);
    add_vec("SLL",      4'b0101, 32'd1,         32'h0000_0021, 32'd2,         1'b0, 1, 0);
    add_vec("SRL",      4'b0110, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1, 0);
    add_vec("SLT",      4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1, 0);
    add_vec("SRA",      4'b1000, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1, 0);
    add_vec("SLTU",     4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1, 0);
    add_vec("ADDWRAP",  4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1, 0);
    add_vec("MUL",      4'b1010, 32'd7,         32'd6,         32'd42,        1'b0, 33, 32);
    add_vec("MULHU",    4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 32);
    add_vec("MULLO",    4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 33, 32);
    add_vec("MULZ",     4'b1010, 32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1, 33, 32);
    add_vec("RSV1110",  4'b1110, 32'd3,         32'd4,         32'd0,         1'b1, 1, 0);
    add_vec("RSV1111",  4'b1111, 32'd3,         32'd4,         32'd0,         1'b1, 1, 0);
`ifdef ALU_MULTICYCLE_DIV_EN
    add_vec("DIVU",     4'b1100, 32'd100,       32'd7,         32'd14,        1'b0, 33, 32);
    add_vec("REMU",     4'b1101, 32'd100,       32'd7,         32'd2,         1'b0, 33, 32);
    add_vec("DIVBIG",   4'b1100, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 1'b0, 33, 32);
    add_vec("DIVU0",    4'b1100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, 0);
    add_vec("REMU0",    4'b1101, 32'd5,         32'd0,         32'd5,         1'b0, 1, 0);
`else
    add_vec("DIVU_OFF", 4'b1100, 32'd100,       32'd7,         32'd0,         1'b1, 1, 0);
    add_vec("REMU_OFF", 4'b1101, 32'd100,       32'd7,         32'd0,         1'b1, 1, 0);
`endif

    // Reset state
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_result",    64'(ALUResult), 64'd0);
    check("rst_zero",      64'(Zero),      64'd1);

    // Release on a falling edge so the first vector lands on the first rising edge with rst_n high.
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, res, z, lat, bcnt);
      check({vq[i].name, "_result"}, 64'(res), 64'(vq[i].res));
      check({vq[i].name, "_zero"},   64'(z),   64'(vq[i].z));
      check({vq[i].name, "_lat"},    64'(lat), 64'(vq[i].lat));
      check({vq[i].name, "_busy"},   64'(bcnt), 64'(vq[i].bsy));
    end

    // Backpressure: hold the ADD result, keep a second request pending meanwhile.
    ALUControl = 4'b0000; SrcA = 32'd3; SrcB = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ALUControl = 4'b0001; SrcA = 32'd9; SrcB = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result",    64'(ALUResult), 64'd7);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready),  64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    check("bp_hold_result", 64'(ALUResult), 64'd7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid",  64'(out_valid), 64'd1);
    check("bp_second_result", 64'(ALUResult), 64'd6);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset partway through a multiply.
    ALUControl = 4'b1010; SrcA = 32'd7; SrcB = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mr_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_in_ready",  64'(in_ready),  64'd1);
    check("mr_busy",      64'(busy),      64'd0);
    check("mr_result",    64'(ALUResult), 64'd0);
    check("mr_zero",      64'(Zero),      64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0000, 32'd1, 32'd1, res, z, lat, bcnt);
    check("mr_add_result", 64'(res), 64'd2);
    check("mr_add_lat",    64'(lat), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mr_no_stale", 64'(seen), 64'd0);
    check("mr_final_result", 64'(ALUResult), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (power of 2, 8..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have ports: SrcA, SrcB  input  WIDTH  operands.
REQ-007 SHALL have port: ALUControl  input  4  opcode.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: ALUResult  output  WIDTH  registered result.
REQ-011 SHALL have port: Zero  output  1  registered (ALUResult == 0).
REQ-012 SHALL have port: busy  output  1  high in MUL or DIV state.

Function
REQ-013 SHALL decode opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU; 1110/1111 reserved.
REQ-014 SHALL use shift amount SrcB[log2(WIDTH)-1:0] only; ADD/SUB wrap modulo 2^WIDTH.
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; in_ready = (state == IDLE).
REQ-016 SHALL accept an operation on a rising edge with in_valid && in_ready, latching SrcA, SrcB, ALUControl.
REQ-017 Opcodes 0000-1001 and reserved: SHALL go IDLE -> DONE; out_valid high the cycle after acceptance (latency 1); reserved opcodes give ALUResult 0, Zero 1.
REQ-018 MUL/MULHU: SHALL go IDLE -> MUL, run exactly WIDTH shift-add iterations (one per cycle, 2*WIDTH-bit accumulator), then DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-019 DIVU/REMU: SHALL go IDLE -> DIV, run exactly WIDTH restoring-division iterations, then DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-020 Divide by zero: SHALL skip DIV, go directly to DONE (latency 1); DIVU gives all ones, REMU gives SrcA.
REQ-021 DONE: out_valid = 1; ALUResult and Zero SHALL remain stable until out_valid && out_ready on a rising edge, then DONE -> IDLE.
REQ-022 SHALL ignore in_valid, SrcA, SrcB, ALUControl changes while not in IDLE.
REQ-023 out_valid SHALL be 0 in IDLE, MUL, DIV; ALUResult and Zero hold their last values outside DONE.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, busy 0, ALUResult 0, Zero 1, and clear iteration counter and accumulators.
REQ-025 Reset during MUL, DIV or DONE SHALL abort the operation; no result for it SHALL ever appear.
REQ-026 First acceptance SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-027 Macro ALU_MULTICYCLE_DIV_EN defined: DIVU/REMU and DIV state SHALL be implemented per REQ-019/020.
REQ-028 Macro ALU_MULTICYCLE_DIV_EN undefined: SHALL omit divider logic and DIV state; opcodes 1100/1101 SHALL behave as reserved (ALUResult 0, Zero 1, latency 1).

Verification
REQ-029 WIDTH=32: ADD 10+5 -> out_valid next cycle, ALUResult 15, Zero 0; SUB 10-10 -> ALUResult 0, Zero 1.
REQ-030 SRA 0x80000000 by SrcB 0x24 (amount 4) -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-031 MUL 7*6 -> 42 with out_valid exactly 33 cycles after acceptance, busy high 32 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV_EN defined: DIVU 100/7 -> 14, REMU 100/7 -> 2 (latency 33); DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5 (latency 1); DIV_EN undefined: DIVU 100/7 -> 0, Zero 1, latency 1.
REQ-033 Backpressure: out_ready low 5 cycles after ADD result -> ALUResult, out_valid stable, in_ready 0, second in_valid not accepted until handshake completes.
REQ-034 rst_n pulsed low at MUL iteration 10 -> out_valid 0 immediately, in_ready 1; after release a new ADD 1+1 returns 2 with no stale MUL result.
